uart_brg_frac: RTL and testbench
================================

// Module: uart_brg_frac
// PURPOSE
//  Runtime-programmable fractional baud-rate generator for the UART TX/RX paths.
//  Produces an oversample strobe (tickOs) and a bit strobe (tickBit = every OSR-th tickOs).
//  A fractional accumulator stretches selected periods by one clk, so non-integer clk/baud ratios
//  average out exactly. A resync input lets the RX realign the bit phase on a start-bit edge.
// PARAMETERS
//  CNT_W        16  width of the integer divisor and period counter
//  FRAC_W       4   width of the fractional divisor and accumulator
//  OSR          16  oversample ticks per bit (>=2)
//  DEFAULT_DIV  10  integer divisor active out of reset (fraction 0)
//  RESYNC_PHASE 8   osCnt value loaded on resync (OSR/2 = mid-bit sampling)
// PORTS
//  clk      in   1       system clock
//  rst_n    in   1       asynchronous reset, active low
//  enable   in   1       1 = run; 0 = freeze counters, ticks held at 0
//  divInt   in   CNT_W   integer divisor; tickOs base period = divInt+1 clks
//  divFrac  in   FRAC_W  fractional divisor, units of 2^-FRAC_W clk
//  divLoad  in   1       1-clk strobe: capture divInt/divFrac into the pending regs
//  resync   in   1       1-clk strobe: restart the period counter and bit phase
//  tickOs   out  1       1-clk oversample strobe (registered)
//  tickBit  out  1       1-clk bit strobe, coincident with a tickOs (registered)
//  pending  out  1       1 = a loaded divisor is not yet active
// BEHAVIOUR
//  - Reset: cnt=0, acc=0, osCnt=0, stretch=0, activeInt=DEFAULT_DIV, activeFrac=0,
//    tickOs=0, tickBit=0, pending=0.
//  - Period: limit = activeInt + stretch. On each enabled clk: if cnt==limit then cnt<=0 and
//    tickOs<=1; else cnt<=cnt+1 and tickOs<=0. Period = limit+1 clks; divInt=0 gives a tickOs
//    every clk unless stretched.
//  - Fraction: on each tickOs edge, {carry,acc} <= acc + activeFrac (FRAC_W+1-bit sum) and
//    stretch <= carry. The carry stretches the next period. Average period =
//    activeInt+1+activeFrac/2^FRAC_W. With activeFrac=0, stretch stays 0.
//  - Bit strobe: on each tickOs edge, osCnt wraps OSR-1 -> 0. tickBit<=1 on the same edge as
//    tickOs when osCnt==OSR-1; otherwise tickBit<=0.
//  - divLoad: captures into the pending regs and sets pending=1. The new values become active
//    on the next tickOs edge; that edge evaluates acc and carry with the new fraction. When
//    enable=0, they become active on the next clk. pending clears on the apply edge.
//    A second divLoad before the apply edge overwrites the first (last wins).
//  - resync (priority over the tick logic, needs no enable): cnt<=0, acc<=0, stretch<=0,
//    osCnt<=RESYNC_PHASE, tickOs<=0, tickBit<=0. Any pending divisor is applied on this edge.
//    The first tickOs follows activeInt+1 clks later.
//  - resync and divLoad in the same clk: the newly presented divisor is applied immediately;
//    pending=0.
//  - enable=0: cnt, acc, osCnt and stretch hold; tickOs=tickBit=0 from the next edge. Counting
//    resumes from the held state when enable returns to 1.
//  - Reset asserted mid-period: all state goes to reset values asynchronously. After release,
//    the first tickOs comes DEFAULT_DIV+1 enabled clks later.
//  - tickOs and tickBit are never asserted in two consecutive clks unless the limit is 0.
// STRUCTURE
//  - Shared package uart_pkg holds the CNT_W/FRAC_W/OSR defaults and the baud divisor constants
//    for standard rates at the system clock.
//  - One natural sub-module: uart_frac_acc (acc register, adder, carry -> stretch).
//    The counter, osCnt and the shadow/pending logic stay in this module.
// TESTING
//  1. Reset release, enable=1, default divisor -> tickOs every 11 clks, tickBit every 176 clks,
//     pending=0.
//  2. divInt=3, divFrac=0, divLoad, then resync -> tickOs period 4, tickBit every 64 clks.
//  3. divInt=3, divFrac=8 (FRAC_W=4), after resync -> tickOs gaps 4,4,5,4,5,...; over 32 ticks
//     exactly 144 clks.
//  4. divLoad divInt=7 mid-period at divInt=3 -> pending=1; current period stays 4; period 8 after
//     the next tickOs; pending=0 on that edge.
//  5. resync at cnt=2, osCnt=5 (divInt=3) -> no tick that clk; tickOs 4 clks later; tickBit after
//     OSR-RESYNC_PHASE=8 tickOs.
//  6. enable low for 20 clks mid-period, then high -> no ticks while low; remaining gap preserved.
//     rst_n pulse mid-run -> outputs 0 immediately, then period 11 from release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: default generator geometry and baud divisors for the system clock.
package uart_pkg;

    localparam int CNT_W_DEF        = 16;
    localparam int FRAC_W_DEF       = 4;
    localparam int OSR_DEF          = 16;
    localparam int DEFAULT_DIV_DEF  = 10;
    localparam int RESYNC_PHASE_DEF = 8;
    localparam int SYS_CLK_HZ       = 50_000_000;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
    } baud_div_t;

    // Oversample period = SYS_CLK_HZ / (baud * 16) = div_int + 1 + div_frac/16 clks
    localparam baud_div_t BAUD_9600   = '{div_int: 16'd324, div_frac: 4'd8};
    localparam baud_div_t BAUD_19200  = '{div_int: 16'd161, div_frac: 4'd12};
    localparam baud_div_t BAUD_57600  = '{div_int: 16'd53,  div_frac: 4'd4};
    localparam baud_div_t BAUD_115200 = '{div_int: 16'd26,  div_frac: 4'd2};

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional phase accumulator: each oversample tick adds the fraction; the carry
// out becomes a one-clk stretch of the following period.
module uart_frac_acc
    import uart_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [FRAC_W-1:0] frac,
    output logic              stretch
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, frac};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (advance) begin
            acc     <= sum[FRAC_W-1:0];
            stretch <= sum[FRAC_W];
        end
    end

endmodule

// File: rtl/uart_brg_frac.sv
// Fractional baud-rate generator: oversample strobe, bit strobe every OSR ticks,
// shadowed runtime divisor and a resync that realigns the bit phase.
module uart_brg_frac
    import uart_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int OSR          = OSR_DEF,
    parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
    parameter int RESYNC_PHASE = RESYNC_PHASE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  divInt,
    input  logic [FRAC_W-1:0] divFrac,
    input  logic              divLoad,
    input  logic              resync,
    output logic              tickOs,
    output logic              tickBit,
    output logic              pending
);

    localparam int              OS_W      = $clog2(OSR);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_RESYNC = OS_W'(RESYNC_PHASE);
    localparam logic [OS_W-1:0] OS_ONE    = OS_W'(1);
    localparam logic [CNT_W:0]  CNT_ONE   = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

    // One extra counter bit so a stretched maximum divisor is still reachable.
    logic [CNT_W:0]    cnt;
    logic [CNT_W:0]    limit;
    logic [OS_W-1:0]   os_cnt;
    logic [CNT_W-1:0]  active_int;
    logic [FRAC_W-1:0] active_frac;
    logic [CNT_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W-1:0] acc_frac;
    logic              stretch;
    logic              tick_edge;
    logic              apply;

    assign limit = {1'b0, active_int} + {{CNT_W{1'b0}}, stretch};

    // >= rather than ==: a divisor applied while frozen may leave cnt above the new limit.
    assign tick_edge = enable && (cnt >= limit);
    assign apply     = pending && (resync || tick_edge || !enable);

    // The apply edge already accumulates with the incoming fraction.
    assign acc_frac = pending ? pend_frac : active_frac;

    uart_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (resync),
        .advance (tick_edge),
        .frac    (acc_frac),
        .stretch (stretch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            os_cnt  <= '0;
            tickOs  <= 1'b0;
            tickBit <= 1'b0;
        end else if (resync) begin
            cnt     <= '0;
            os_cnt  <= OS_RESYNC;
            tickOs  <= 1'b0;
            tickBit <= 1'b0;
        end else if (tick_edge) begin
            cnt     <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
            tickOs  <= 1'b1;
            tickBit <= (os_cnt == OS_LAST);
        end else begin
            if (enable) begin
                cnt <= cnt + CNT_ONE;
            end
            tickOs  <= 1'b0;
            tickBit <= 1'b0;
        end
    end

    // Shadow divisor: last load wins; resync with a simultaneous load takes the inputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_int  <= DIV_RST;
            active_frac <= '0;
            pend_int    <= DIV_RST;
            pend_frac   <= '0;
            pending     <= 1'b0;
        end else begin
            if (resync && divLoad) begin
                active_int  <= divInt;
                active_frac <= divFrac;
            end else if (apply) begin
                active_int  <= pend_int;
                active_frac <= pend_frac;
            end
            if (divLoad) begin
                pend_int  <= divInt;
                pend_frac <= divFrac;
            end
            if (resync) begin
                pending <= 1'b0;
            end else if (divLoad) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_brg_frac.sv
// Bench for uart_brg_frac: directed scenarios plus random divisors, checked against
// closed-form tick times (tick k at k*(div+1) + floor((k-1)*frac/16) clks after alignment).
module tb_uart_brg_frac;

    localparam int OSR        = 16;
    localparam int FRAC_SCALE = 16;
    localparam int DEF_DIV    = 10;
    localparam int PHASE      = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] divInt;
    logic [3:0]  divFrac;
    logic        divLoad;
    logic        resync;
    logic        tickOs;
    logic        tickBit;
    logic        pending;

    int checks = 0;
    int errors = 0;

    // Reference model state: divisor, bit phase, cycles since alignment, next tick index.
    int m_d, m_f, m_phase, m_c, m_k;
    int tick_times[$];
    int bit_times[$];

    uart_brg_frac dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .divInt  (divInt),
        .divFrac (divFrac),
        .divLoad (divLoad),
        .resync  (resync),
        .tickOs  (tickOs),
        .tickBit (tickBit),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int t_of(input int k);
        return k * (m_d + 1) + ((k - 1) * m_f) / FRAC_SCALE;
    endfunction

    task automatic model_reset(input int d, input int f, input int phase);
        m_d = d;
        m_f = f;
        m_phase = phase;
        m_c = 0;
        m_k = 1;
        tick_times.delete();
        bit_times.delete();
    endtask

    task automatic check_cycles(input int n, input string tag);
        logic exp_os, exp_bit;
        for (int i = 0; i < n; i++) begin
            step();
            m_c++;
            exp_os  = (m_c == t_of(m_k));
            exp_bit = exp_os && (((m_phase + m_k - 1) % OSR) == OSR - 1);
            if (exp_os) m_k++;
            chk_bit({tag, "_tickOs"}, tickOs, exp_os);
            chk_bit({tag, "_tickBit"}, tickBit, exp_bit);
            if (tickOs === 1'b1) tick_times.push_back(m_c);
            if (tickBit === 1'b1) bit_times.push_back(m_c);
        end
    endtask

    task automatic resync_load(input int d, input int f);
        divInt  = 16'(d);
        divFrac = 4'(f);
        divLoad = 1'b1;
        resync  = 1'b1;
        step();
        divLoad = 1'b0;
        resync  = 1'b0;
        chk_bit("resync_load_pending", pending, 1'b0);
        chk_bit("resync_load_tickOs", tickOs, 1'b0);
        model_reset(d, f, PHASE);
    endtask

    initial begin
        int d, f;
        bit found;

        rst_n   = 1'b0;
        enable  = 1'b0;
        divInt  = '0;
        divFrac = '0;
        divLoad = 1'b0;
        resync  = 1'b0;

        // Reset state
        repeat (3) step();
        chk_bit("rst_tickOs", tickOs, 1'b0);
        chk_bit("rst_tickBit", tickBit, 1'b0);
        chk_bit("rst_pending", pending, 1'b0);

        // Default divisor: period 11, bit every 176
        enable = 1'b1;
        rst_n  = 1'b1;
        model_reset(DEF_DIV, 0, 0);
        check_cycles(200, "default");
        chk_bit("default_pending", pending, 1'b0);
        chk_int("default_first_tick", (tick_times.size() > 0) ? tick_times[0] : -1, 11);
        chk_int("default_first_bit", (bit_times.size() > 0) ? bit_times[0] : -1, 176);

        // Load then resync: period 4, bit every 64
        divInt  = 16'd3;
        divFrac = 4'd0;
        divLoad = 1'b1;
        step();
        divLoad = 1'b0;
        chk_bit("load_pending_set", pending, 1'b1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk_bit("resync_applies_pending", pending, 1'b0);
        chk_bit("resync_tickOs", tickOs, 1'b0);
        model_reset(3, 0, PHASE);
        check_cycles(130, "div3");
        chk_int("div3_bits", bit_times.size(), 2);
        if (bit_times.size() >= 2)
            chk_int("div3_bit_gap", bit_times[1] - bit_times[0], 64);

        // Fractional 3 + 8/16: 32 tick gaps total 144 clks
        resync_load(3, 8);
        check_cycles(150, "frac");
        chk_int("frac_enough_ticks", (tick_times.size() >= 33) ? 1 : 0, 1);
        if (tick_times.size() >= 33) begin
            chk_int("frac_gap1", tick_times[1] - tick_times[0], 4);
            chk_int("frac_gap2", tick_times[2] - tick_times[1], 5);
            chk_int("frac_32_ticks", tick_times[32] - tick_times[0], 144);
        end

        // Mid-period load: current period stays 4, then 8
        resync_load(3, 0);
        check_cycles(2, "midload_pre");
        divInt  = 16'd7;
        divLoad = 1'b1;
        step();
        divLoad = 1'b0;
        chk_bit("midload_pending", pending, 1'b1);
        chk_bit("midload_c3_tick", tickOs, 1'b0);
        step();
        chk_bit("midload_c4_tick", tickOs, 1'b1);
        chk_bit("midload_c4_pending", pending, 1'b0);
        for (int c = 5; c <= 20; c++) begin
            step();
            chk_bit("midload_period8", tickOs, (c == 12 || c == 20));
            chk_bit("midload_pending_clr", pending, 1'b0);
        end

        // Resync at cnt=2, osCnt=5
        resync_load(3, 0);
        check_cycles(54, "pre_resync");
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk_bit("resync_no_tick", tickOs, 1'b0);
        chk_bit("resync_no_bit", tickBit, 1'b0);
        model_reset(3, 0, PHASE);
        check_cycles(40, "post_resync");
        chk_int("post_resync_first_tick", (tick_times.size() > 0) ? tick_times[0] : -1, 4);
        chk_int("post_resync_first_bit", (bit_times.size() > 0) ? bit_times[0] : -1, 32);

        // Enable low mid-period; a load while frozen applies on the next clk
        resync_load(3, 0);
        check_cycles(2, "en_pre");
        enable  = 1'b0;
        divInt  = 16'd3;
        divFrac = 4'd0;
        divLoad = 1'b1;
        step();
        divLoad = 1'b0;
        chk_bit("en_low_pending_set", pending, 1'b1);
        chk_bit("en_low_tick0", tickOs, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step();
            chk_bit("en_low_tickOs", tickOs, 1'b0);
            chk_bit("en_low_tickBit", tickBit, 1'b0);
            chk_bit("en_low_pending_clr", pending, 1'b0);
        end
        enable = 1'b1;
        check_cycles(40, "en_resume");
        chk_int("en_resume_first_tick", (tick_times.size() > 0) ? tick_times[0] : -1, 4);

        // Random divisors against the closed-form model
        for (int t = 0; t < 5; t++) begin
            d = int'($urandom_range(0, 12));
            f = int'($urandom_range(0, 15));
            resync_load(d, f);
            check_cycles((d + 2) * 40, "random");
        end

        // Reset pulse while a tick is showing and a load is pending
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            divLoad = 1'b1;
            step();
            if (tickOs === 1'b1) found = 1'b1;
        end
        chk_bit("rst_pulse_found_tick", found, 1'b1);
        chk_bit("rst_pulse_pending_pre", pending, 1'b1);
        divLoad = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk_bit("rst_pulse_async_tickOs", tickOs, 1'b0);
        chk_bit("rst_pulse_async_pending", pending, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        model_reset(DEF_DIV, 0, 0);
        check_cycles(60, "after_rst");
        chk_int("after_rst_first_tick", (tick_times.size() > 0) ? tick_times[0] : -1, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
